// File: rtl/uart_rx_param.sv
// Purpose: parametrised UART receiver (data width, parity, stop bits, oversampling) with FWFT word FIFO.
// Latency: rx_p to rx_s 2 cycles; word visible on fifo_dout_p 1 cycle after the WRITE state.
// Backpressure: none on the line; a good word arriving at a full FIFO is dropped with an overrun pulse.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 32,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk210_p,
    input  logic                 reset_p,
    input  logic                 rx_p,
    input  logic                 baud_tick_p,
    input  logic                 fifo_rd_en_p,
    output logic [DATA_BITS-1:0] fifo_dout_p,
    output logic                 fifo_empty_p,
    output logic                 fifo_full_p,
    output logic [AW:0]          fifo_count_p,
    output logic                 frame_err_p,
    output logic                 parity_err_p,
    output logic                 overrun_err_p,
    output logic                 break_p,
    output logic                 rx_busy_p
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WRITE     = 3'd5,
        WAIT_HIGH = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_q, stop_d;
    logic                  fe_q, fe_d, pe_q, pe_d, ov_q, ov_d, brk_q, brk_d;
    logic                  wr_en;

    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d;
    logic                  rd_fire;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_p;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM next state: tick counter restarts on every sample/state change.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        stop_d    = stop_q;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
        ov_d      = 1'b0;
        brk_d     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d    = '0;
                par_bit_d = 1'b0;
                par_err_d = 1'b0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (baud_tick_p) begin
                    if (tick_q == T_MID) begin
                        tick_d = '0;
                        bit_d  = '0;
                        // A high line at mid-start is a glitch, not a frame.
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick_p) begin
                    if (tick_q == T_END) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == B_LAST) begin
                            stop_d  = 1'b0;
                            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick_p) begin
                    if (tick_q == T_END) begin
                        tick_d    = '0;
                        par_bit_d = rx_s_q;
                        par_err_d = (PARITY_MODE == 1) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
                        stop_d    = 1'b0;
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick_p) begin
                    if (tick_q == T_END) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            // All-zero frame with a low stop is a break, not a framing error.
                            if ((shift_q == '0) && !par_bit_q) begin
                                brk_d = 1'b1;
                            end else begin
                                fe_d = 1'b1;
                                pe_d = par_err_q;
                            end
                            state_d = WAIT_HIGH;
                        end else if (stop_q == S_LAST) begin
                            if (par_err_q) begin
                                pe_d    = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = WRITE;
                            end
                        end else begin
                            stop_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                // A same-cycle pop frees a slot, so a full FIFO can still accept.
                if (!fifo_full_p || fifo_rd_en_p) wr_en = 1'b1;
                else                              ov_d  = 1'b1;
            end
            WAIT_HIGH: begin
                tick_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM state and registered one-cycle status pulses.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            stop_q    <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ov_q      <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            stop_q    <= stop_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ov_q      <= ov_d;
            brk_q     <= brk_d;
        end
    end

    assign rd_fire = fifo_rd_en_p && !fifo_empty_p;

    // Occupancy next value; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk210_p) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign fifo_empty_p  = (count_q == '0);
    assign fifo_full_p   = (count_q == CNT_FULL);
    assign fifo_count_p  = count_q;
    assign fifo_dout_p   = fifo_empty_p ? '0 : mem_q[rd_ptr_q];
    assign frame_err_p   = fe_q;
    assign parity_err_p  = pe_q;
    assign overrun_err_p = ov_q;
    assign break_p       = brk_q;
    assign rx_busy_p     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7N2) share clock/tick/reset;
// a selector routes the serial line and pops to one instance at a time.
// Expected words are queued when a frame is sent and compared as the FIFO drains.
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic tick  = 1'b0;
    logic line  = 1'b1;
    logic rd    = 1'b0;
    int   sel   = 0;

    logic rx0, rx1, rx2, rd0, rd1, rd2;
    assign rx0 = (sel == 0) ? line : 1'b1;
    assign rx1 = (sel == 1) ? line : 1'b1;
    assign rx2 = (sel == 2) ? line : 1'b1;
    assign rd0 = (sel == 0) && rd;
    assign rd1 = (sel == 1) && rd;
    assign rd2 = (sel == 2) && rd;

    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic       empty0, empty1, empty2, full0, full1, full2;
    logic [5:0] cnt0, cnt1, cnt2;
    logic       fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, bk0, bk1, bk2;
    logic       busy0, busy1, busy2;

    uart_rx_param u_def (
        .clk210_p(clk), .reset_p(reset), .rx_p(rx0), .baud_tick_p(tick), .fifo_rd_en_p(rd0),
        .fifo_dout_p(dout0), .fifo_empty_p(empty0), .fifo_full_p(full0), .fifo_count_p(cnt0),
        .frame_err_p(fe0), .parity_err_p(pe0), .overrun_err_p(ov0), .break_p(bk0), .rx_busy_p(busy0));

    uart_rx_param #(.PARITY_MODE(2)) u_par (
        .clk210_p(clk), .reset_p(reset), .rx_p(rx1), .baud_tick_p(tick), .fifo_rd_en_p(rd1),
        .fifo_dout_p(dout1), .fifo_empty_p(empty1), .fifo_full_p(full1), .fifo_count_p(cnt1),
        .frame_err_p(fe1), .parity_err_p(pe1), .overrun_err_p(ov1), .break_p(bk1), .rx_busy_p(busy1));

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_d7 (
        .clk210_p(clk), .reset_p(reset), .rx_p(rx2), .baud_tick_p(tick), .fifo_rd_en_p(rd2),
        .fifo_dout_p(dout2), .fifo_empty_p(empty2), .fifo_full_p(full2), .fifo_count_p(cnt2),
        .frame_err_p(fe2), .parity_err_p(pe2), .overrun_err_p(ov2), .break_p(bk2), .rx_busy_p(busy2));

    logic [8:0] dout_s;
    logic       empty_s, full_s, busy_s;
    logic [5:0] cnt_s;
    assign dout_s  = (sel == 0) ? {1'b0, dout0} : (sel == 1) ? {1'b0, dout1} : {2'b0, dout2};
    assign empty_s = (sel == 0) ? empty0 : (sel == 1) ? empty1 : empty2;
    assign full_s  = (sel == 0) ? full0  : (sel == 1) ? full1  : full2;
    assign busy_s  = (sel == 0) ? busy0  : (sel == 1) ? busy1  : busy2;
    assign cnt_s   = (sel == 0) ? cnt0   : (sel == 1) ? cnt1   : cnt2;

    // Used only to line a pop up with the write cycle of the default instance.
    logic [2:0] def_state;
    assign def_state = u_def.state_q;

    int n_assert = 0;
    int n_fail   = 0;
    int fe[3], pe[3], ov[3], bk[3];
    logic [8:0] exp_q[$];

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (fe0) fe[0]++;
        if (fe1) fe[1]++;
        if (fe2) fe[2]++;
        if (pe0) pe[0]++;
        if (pe1) pe[1]++;
        if (pe2) pe[2]++;
        if (ov0) ov[0]++;
        if (ov1) ov[1]++;
        if (ov2) ov[2]++;
        if (bk0) bk[0]++;
        if (bk1) bk[1]++;
        if (bk2) bk[2]++;
    end

    // Baud tick: one cycle high every four cycles (16x oversampling -> 64 cycles per bit).
    initial begin
        forever begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic bit_wait();
        repeat (64) @(negedge clk);
    endtask

    // Drives start, data LSB first, optional parity, stop bits, then two idle bit times.
    task automatic send_frame(input logic [8:0] d, input int nbits, input int has_par,
                              input logic pbit, input int nstop, input logic stop2);
        line = 1'b0;
        bit_wait();
        for (int i = 0; i < nbits; i++) begin
            line = d[i];
            bit_wait();
        end
        if (has_par != 0) begin
            line = pbit;
            bit_wait();
        end
        line = 1'b1;
        bit_wait();
        if (nstop == 2) begin
            line = stop2;
            bit_wait();
        end
        line = 1'b1;
        bit_wait();
        bit_wait();
    endtask

    task automatic drain(input string tag, input int n);
        logic [8:0] e;
        chk({tag, "_count"}, 32'(cnt_s), 32'(n));
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
            chk({tag, "_nonempty"}, 32'(empty_s), 32'd0);
            chk({tag, "_dout"}, 32'(dout_s), 32'(e));
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_empty_after"}, 32'(empty_s), 32'd1);
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] seq4 [4];
        bit seen;
        seq4[0] = 8'h55; seq4[1] = 8'hA3; seq4[2] = 8'h00; seq4[3] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_full",  32'(full0),  32'd0);
        chk("rst_count", 32'(cnt0),   32'd0);
        chk("rst_busy",  32'(busy0),  32'd0);
        chk("rst_dout",  32'(dout0),  32'd0);
        chk("rst_pulses", 32'({fe0, pe0, ov0, bk0}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1: four bytes in order
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, seq4[i]});
            send_frame({1'b0, seq4[i]}, 8, 0, 1'b0, 1, 1'b1);
        end
        chk("four_errs", 32'(fe[0] + pe[0] + ov[0] + bk[0]), 32'd0);
        drain("four", 4);

        // Start glitch of 4 ticks
        line = 1'b0;
        repeat (16) @(negedge clk);
        line = 1'b1;
        bit_wait();
        bit_wait();
        chk("glitch_busy", 32'(busy_s), 32'd0);
        chk("glitch_count", 32'(cnt_s), 32'd0);
        chk("glitch_errs", 32'(fe[0] + pe[0] + ov[0] + bk[0]), 32'd0);
        exp_q.push_back(9'h03C);
        send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1);
        drain("after_glitch", 1);

        // Overrun: 33 frames without reads
        for (int i = 0; i < 33; i++) begin
            v = 8'(i * 37 + 5);
            if (i < 32) exp_q.push_back({1'b0, v});
            send_frame({1'b0, v}, 8, 0, 1'b0, 1, 1'b1);
        end
        chk("ovr_count", 32'(cnt_s), 32'd32);
        chk("ovr_full", 32'(full_s), 32'd1);
        chk("ovr_pulses", 32'(ov[0]), 32'd1);

        // 34th frame with a pop in the very write cycle
        v = 8'hC7;
        seen = 1'b0;
        fork
            send_frame({1'b0, v}, 8, 0, 1'b0, 1, 1'b1);
            begin
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge clk);
                    if (def_state == 3'd5) seen = 1'b1;
                end
                chk("wr34_seen", 32'(seen), 32'd1);
                if (seen) begin
                    chk("wr34_head", 32'(dout_s), 32'(exp_q.pop_front()));
                    rd = 1'b1;
                    @(negedge clk);
                    rd = 1'b0;
                end
            end
        join
        exp_q.push_back({1'b0, v});
        chk("wr34_count", 32'(cnt_s), 32'd32);
        chk("wr34_ovr", 32'(ov[0]), 32'd1);
        drain("full_drain", 32);

        // Break: line low for three frame times
        line = 1'b0;
        repeat (30) bit_wait();
        line = 1'b1;
        bit_wait();
        bit_wait();
        chk("brk_pulses", 32'(bk[0]), 32'd1);
        chk("brk_no_fe", 32'(fe[0]), 32'd0);
        chk("brk_count", 32'(cnt_s), 32'd0);
        exp_q.push_back(9'h05A);
        send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1);
        drain("after_brk", 1);

        // Even parity: 0x81 has even ones, so parity bit 1 is wrong
        sel = 1;
        send_frame(9'h081, 8, 1, 1'b1, 1, 1'b1);
        chk("par_bad_pe", 32'(pe[1]), 32'd1);
        chk("par_bad_fe", 32'(fe[1]), 32'd0);
        chk("par_bad_empty", 32'(empty_s), 32'd1);
        exp_q.push_back(9'h081);
        send_frame(9'h081, 8, 1, 1'b0, 1, 1'b1);
        chk("par_ok_pe", 32'(pe[1]), 32'd1);
        drain("par_ok", 1);

        // 7 data bits, 2 stop bits, second stop low
        sel = 2;
        send_frame(9'h041, 7, 0, 1'b0, 2, 1'b0);
        chk("d7_fe", 32'(fe[2]), 32'd1);
        chk("d7_empty", 32'(empty_s), 32'd1);
        send_frame(9'h041, 7, 0, 1'b0, 2, 1'b1);
        chk("d7_good_count", 32'(cnt_s), 32'd1);
        chk("d7_good_dout", 32'(dout_s), 32'h41);

        // Reset mid-frame with one word held
        line = 1'b0;
        repeat (3) bit_wait();
        chk("midrst_busy_before", 32'(busy_s), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_empty", 32'(empty_s), 32'd1);
        chk("midrst_busy", 32'(busy_s), 32'd0);
        chk("midrst_count", 32'(cnt_s), 32'd0);
        reset = 1'b0;
        line  = 1'b1;
        exp_q.delete();
        repeat (3) bit_wait();
        chk("midrst_idle", 32'(busy_s), 32'd0);
        chk("midrst_no_err", 32'(fe[2] + pe[2] + bk[2]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the satellite FPGA's serial links, the next generation of the fixed 8N1 receiver. Supports configurable data width, parity, stop bits and oversampling ratio. Adds start-bit glitch rejection, framing, parity, overrun and break detection, and an internal first-word-fall-through FIFO of configurable depth. It sits between the board RX pin and the UART top-level decoder, which drains the FIFO.

## Interface
Parameters:
- DATA_BITS, 8: payload bits per frame, legal range 5..9, sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: ticks per bit; must be even and ≥ 8.
- FIFO_DEPTH, 32: power of two, ≥ 2; AW = log2(FIFO_DEPTH).

Ports:
- clk210_p, in, 1: system clock. One clock; reset is synchronous and active-high.
- reset_p, in, 1: synchronous active-high reset.
- rx_p, in, 1: asynchronous serial line; idles high.
- baud_tick_p, in, 1: single-cycle pulse at OVERSAMPLE × baud; never asserted on consecutive cycles.
- fifo_rd_en_p, in, 1: pop the head word.
- fifo_dout_p, out, DATA_BITS: head word (FWFT); valid while !fifo_empty_p.
- fifo_empty_p, out, 1: FIFO empty.
- fifo_full_p, out, 1: FIFO full.
- fifo_count_p, out, AW+1: words held, 0..FIFO_DEPTH.
- frame_err_p, out, 1: one-cycle pulse when a stop bit is sampled low on a non-break frame.
- parity_err_p, out, 1: one-cycle pulse on parity mismatch.
- overrun_err_p, out, 1: one-cycle pulse when a good word is dropped because the FIFO is full.
- break_p, out, 1: one-cycle pulse on a break frame (all data, parity and stop samples low).
- rx_busy_p, out, 1: high in any state other than IDLE.

## Operation
- rx_p passes through a 2-flop synchronizer (rx_s), reset to 1. All sampling uses rx_s.
- Counters: tick_cnt counts baud ticks and resets to 0 on every state change; bit_cnt counts data bits 0..DATA_BITS-1.
- State machine states: IDLE, START, DATA, PARITY, STOP, WRITE, WAIT_HIGH.
- IDLE: when rx_s == 0, go to START with tick_cnt = 0.
- START: on the tick where tick_cnt == OVERSAMPLE/2-1, sample mid-start.
  - rx_s == 1: glitch; return to IDLE with no flag.
  - rx_s == 0: go to DATA.
- DATA: on the tick where tick_cnt == OVERSAMPLE-1, shift rx_s in at the MSB (LSB-first frame).
  - After DATA_BITS samples, go to PARITY if PARITY_MODE ≠ 0, else STOP.
- PARITY: sample at tick OVERSAMPLE-1.
  - Mismatch: if XOR(data, parity bit) ≠ 1 for odd, or ≠ 0 for even.
- STOP: sample at tick OVERSAMPLE-1, STOP_BITS times.
  - Every stop sample 1: go to WRITE if parity was OK.
  - Parity mismatch with a good stop: pulse parity_err_p, drop the word, go to IDLE.
  - Any stop sample 0 with data == 0 and parity sample 0 (or no parity): pulse break_p, drop, go to WAIT_HIGH.
  - Any other stop sample 0: pulse frame_err_p (also parity_err_p if mismatched), drop, go to WAIT_HIGH.
  - Evaluate after the last stop sample, or immediately on the first 0 stop sample.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a held-low line from re-triggering a start.
- WRITE: one cycle, then IDLE.
  - Word is written if the FIFO is not full, or if it is full and fifo_rd_en_p is high in the same cycle.
  - Otherwise pulse overrun_err_p and drop the word.
- FIFO: circular buffer with AW-bit read/write pointers that wrap modulo FIFO_DEPTH.
  - fifo_rd_en_p while empty is ignored.
  - Simultaneous read and write: count unchanged, both pointers advance.
- Reset mid-frame: state returns to IDLE, the FIFO empties, and the partial word is discarded.

## Timing
- Reset values: fifo_empty_p = 1, fifo_full_p = 0, fifo_count_p = 0, all error pulses = 0, rx_busy_p = 0, fifo_dout_p = 0.
- rx_p to rx_s: 2 cycles.
- IDLE exit: 1 cycle after rx_s falls.
- Bit samples fall at mid-bit: OVERSAMPLE/2 + k·OVERSAMPLE ticks after start detection.
- WRITE to visible data: fifo_empty_p deasserts and fifo_dout_p is valid 1 cycle after WRITE.
- fifo_count_p and flags update 1 cycle after wr/rd.
- Error and break pulses: 1 cycle wide, asserted in the cycle after the deciding sample.

## Test plan
- Defaults (8N1, OS16), bytes 0x55, 0xA3, 0x00, 0xFF → FIFO holds the same four bytes in order; count = 4; no error flags.
- PARITY_MODE = 2, frame 0x81 with parity bit 1 → parity_err_p pulses once; FIFO stays empty.
  - Same frame with parity bit 0 → 0x81 is written.
- Start glitch of 4 ticks low, then line idle → no write and no flag; busy returns low.
  - Next a valid 0x3C frame → 0x3C is received.
- Defaults, 33 frames sent with no reads → count = 32, full = 1, overrun_err_p pulses once, first 32 bytes intact.
  - Then read while writing the 34th frame → write is accepted; count stays 32.
- Line held low for 3 frame times → one break_p pulse, no frame_err_p, no write.
  - After the line returns high, 0x5A is received correctly.
- DATA_BITS = 7, STOP_BITS = 2, 0x41 with the second stop bit low → frame_err_p pulses and the word is dropped.
  - Assert reset_p mid-frame → empty = 1, busy = 0 the next cycle.
